// File: rtl/frame_config_pkg.sv
// Shared constants and types for the fabric configuration sequencer.
// Header layout: column in [31:24], frame in [23:16], [15:0] reserved.
package frame_config_pkg;

    localparam logic [31:0] SYNC_WORD   = 32'hFAB0_FAB1;
    localparam logic [31:0] DESYNC_WORD = 32'hFAB0_FAB0;

    localparam int HDR_COL_MSB   = 31;
    localparam int HDR_COL_LSB   = 24;
    localparam int HDR_FRAME_MSB = 23;
    localparam int HDR_FRAME_LSB = 16;
    localparam int HDR_FIELD_W   = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HDR    = 2'd1,
        DATA   = 2'd2,
        STROBE = 2'd3
    } state_t;

endpackage

// File: rtl/frame_strobe_gen.sv
// One-hot FrameStrobe decoder plus the pulse-width counter that holds the
// selected strobe bit for exactly StrobeCycles clocks after a start request.
module frame_strobe_gen
    import frame_config_pkg::*;
#(
    parameter int NumColumns      = 4,
    parameter int MaxFramesPerCol = 20,
    parameter int StrobeCycles    = 2
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  start,
    input  logic [HDR_FIELD_W-1:0]                col,
    input  logic [HDR_FIELD_W-1:0]                frame,
    output logic [NumColumns*MaxFramesPerCol-1:0] strobe,
    output logic                                  busy,
    output logic                                  last
);

    localparam int STROBE_W = NumColumns * MaxFramesPerCol;
    localparam int CNT_W    = (StrobeCycles > 1) ? $clog2(StrobeCycles) : 1;

    logic [STROBE_W-1:0] strobe_decoded;
    logic [STROBE_W-1:0] strobe_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                busy_q;

    // Out-of-range addresses decode to all zeros, so a bad header can never light a bit.
    always_comb begin
        strobe_decoded = '0;
        for (int c = 0; c < NumColumns; c++) begin
            for (int f = 0; f < MaxFramesPerCol; f++) begin
                if ((col == HDR_FIELD_W'(c)) && (frame == HDR_FIELD_W'(f))) begin
                    strobe_decoded[c*MaxFramesPerCol+f] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            strobe_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else if (start) begin
            strobe_q <= strobe_decoded;
            cnt_q    <= CNT_W'(StrobeCycles - 1);
            busy_q   <= 1'b1;
        end else if (busy_q) begin
            if (cnt_q == '0) begin
                strobe_q <= '0;
                busy_q   <= 1'b0;
            end else begin
                cnt_q <= cnt_q - CNT_W'(1);
            end
        end
    end

    assign strobe = strobe_q;
    assign busy   = busy_q;
    assign last   = busy_q && (cnt_q == '0);

endmodule

// File: rtl/frame_config_ctrl.sv
// Configuration sequencer: assembles one frame per header from the bitstream
// and strobes it into the addressed column/frame of the tile array.
module frame_config_ctrl
    import frame_config_pkg::*;
#(
    parameter int NumColumns      = 4,
    parameter int NumRows         = 4,
    parameter int FrameBitsPerRow = 32,
    parameter int MaxFramesPerCol = 20,
    parameter int StrobeCycles    = 2
) (
    input  logic                                  CLK,
    input  logic                                  RST,
    input  logic [31:0]                           s_data,
    input  logic                                  s_valid,
    output logic                                  s_ready,
    output logic [NumRows*FrameBitsPerRow-1:0]    FrameData,
    output logic [NumColumns*MaxFramesPerCol-1:0] FrameStrobe,
    output logic                                  MODE,
    output logic                                  cfg_err,
    output logic [15:0]                           frames_done
);

    localparam int ROW_W = (NumRows > 1) ? $clog2(NumRows) : 1;

    state_t                 state;
    state_t                 state_next;
    logic [HDR_FIELD_W-1:0] col_q;
    logic [HDR_FIELD_W-1:0] frame_q;
    logic                   skip_q;
    logic [ROW_W-1:0]       row_q;

    logic                   accept;
    logic [HDR_FIELD_W-1:0] hdr_col;
    logic [HDR_FIELD_W-1:0] hdr_frame;
    logic                   hdr_bad;
    logic                   last_row;
    logic                   strobe_start;
    logic                   strobe_busy;
    logic                   strobe_last;

    assign s_ready      = (state != STROBE);
    assign accept       = s_valid && s_ready;
    assign hdr_col      = s_data[HDR_COL_MSB:HDR_COL_LSB];
    assign hdr_frame    = s_data[HDR_FRAME_MSB:HDR_FRAME_LSB];
    assign hdr_bad      = (32'(hdr_col) >= 32'(NumColumns)) ||
                          (32'(hdr_frame) >= 32'(MaxFramesPerCol));
    assign last_row     = (row_q == ROW_W'(NumRows - 1));
    assign strobe_start = (state == DATA) && accept && last_row && !skip_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // SYNC and DESYNC only carry meaning in IDLE and HDR; inside DATA they are payload.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept && (s_data == SYNC_WORD)) begin
                    state_next = HDR;
                end
            end
            HDR: begin
                if (accept) begin
                    state_next = (s_data == DESYNC_WORD) ? IDLE : DATA;
                end
            end
            DATA: begin
                if (accept && last_row) begin
                    state_next = skip_q ? HDR : STROBE;
                end
            end
            STROBE: begin
                if (strobe_last || !strobe_busy) begin
                    state_next = HDR;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            FrameData   <= '0;
            MODE        <= 1'b0;
            cfg_err     <= 1'b0;
            frames_done <= '0;
            col_q       <= '0;
            frame_q     <= '0;
            skip_q      <= 1'b0;
            row_q       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept && (s_data == SYNC_WORD)) begin
                        MODE        <= 1'b1;
                        frames_done <= '0;
                        cfg_err     <= 1'b0;
                    end
                end
                HDR: begin
                    if (accept) begin
                        if (s_data == DESYNC_WORD) begin
                            MODE <= 1'b0;
                        end else begin
                            col_q   <= hdr_col;
                            frame_q <= hdr_frame;
                            row_q   <= '0;
                            skip_q  <= hdr_bad;
                            if (hdr_bad) begin
                                cfg_err <= 1'b1;
                            end
                        end
                    end
                end
                DATA: begin
                    if (accept) begin
                        FrameData[row_q*FrameBitsPerRow +: FrameBitsPerRow] <= s_data;
                        row_q <= row_q + ROW_W'(1);
                    end
                end
                STROBE: begin
                    if (strobe_last && (frames_done != 16'hFFFF)) begin
                        frames_done <= frames_done + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    frame_strobe_gen #(
        .NumColumns      (NumColumns),
        .MaxFramesPerCol (MaxFramesPerCol),
        .StrobeCycles    (StrobeCycles)
    ) u_strobe_gen (
        .clk    (CLK),
        .rst    (RST),
        .start  (strobe_start),
        .col    (col_q),
        .frame  (frame_q),
        .strobe (FrameStrobe),
        .busy   (strobe_busy),
        .last   (strobe_last)
    );

endmodule
